// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port among N_SRC writeback requesters.
// The valid/ready grant is combinational. The winning write is registered
// onto the register-file port. A forwarding path exposes that in-flight write
// for the one cycle before the register file can return it.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN.
//   Defined   -> round-robin arbitration starting after the last granted index.
//   Undefined -> fixed priority, where the lowest index wins.

module regfile_wb_arbiter #(
  parameter int N_SRC = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_SRC-1:0]      req_valid_i,
  output logic [N_SRC-1:0]      req_ready_o,
  input  logic [N_SRC*AW-1:0]   req_waddr_i,
  input  logic [N_SRC*DW-1:0]   req_wdata_i,
  output logic                  rf_we_o,
  output logic [AW-1:0]         rf_waddr_o,
  output logic [DW-1:0]         rf_wdata_o,
  input  logic [AW-1:0]         fwd_raddr1_i,
  input  logic [AW-1:0]         fwd_raddr2_i,
  output logic                  fwd_hit1_o,
  output logic                  fwd_hit2_o,
  output logic [DW-1:0]         fwd_data1_o,
  output logic [DW-1:0]         fwd_data2_o
);

  // One-hot grant and its encoded index (3 bits covers up to 8 sources).
  logic [N_SRC-1:0] grant;
  logic [2:0]       grant_idx;
  logic             grant_found;
  // Most recently granted index; resets to N_SRC-1 so that source 0 is searched first.
  logic [2:0]       last_q;
  // Address and data of the granted requester.
  logic [AW-1:0]    sel_waddr;
  logic [DW-1:0]    sel_wdata;
  logic             transfer;

`ifdef WB_ARB_ROUND_ROBIN_EN
  int               rr_idx;

  // Round-robin search: start just after last_q, ascend with wrap, and grant the first valid requester.
  always_comb begin
    grant       = '0;
    grant_idx   = 3'd0;
    grant_found = 1'b0;
    rr_idx      = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      rr_idx = (int'(last_q) + k) % N_SRC;
      if (!grant_found && req_valid_i[rr_idx]) begin
        grant_found    = 1'b1;
        grant[rr_idx]  = 1'b1;
        grant_idx      = rr_idx[2:0];
      end else begin
        grant_found    = grant_found;
      end
    end
  end
`else
  // last_q is maintained but is not consulted when fixed priority is used.
  logic unused_last_q;
  assign unused_last_q = ^last_q;

  // Fixed priority: the lowest-index valid requester wins.
  always_comb begin
    grant       = '0;
    grant_idx   = 3'd0;
    grant_found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!grant_found && req_valid_i[i]) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = 3'(i);
      end else begin
        grant_found = grant_found;
      end
    end
  end
`endif

  // Hold ready low during reset so that no handshake completes while the output register is cleared.
  assign req_ready_o = rst_ni ? grant : '0;
  assign transfer    = grant_found;

  // Select the address and data of the granted requester.
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        sel_waddr = req_waddr_i[i*AW +: AW];
        sel_wdata = req_wdata_i[i*DW +: DW];
      end else begin
        sel_waddr = sel_waddr;
        sel_wdata = sel_wdata;
      end
    end
  end

  // Register the granted write. An accepted write to x0 completes but never asserts the write enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (transfer) begin
      rf_we_o    <= (sel_waddr != '0);
      rf_waddr_o <= sel_waddr;
      rf_wdata_o <= sel_wdata;
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

  // Track the most recently granted index. It changes only on a completed transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 3'(N_SRC - 1);
    end else if (transfer) begin
      last_q <= grant_idx;
    end else begin
      last_q <= last_q;
    end
  end

  // Forwarding compare against the write the register file has not captured yet; x0 never forwards.
  always_comb begin
    fwd_hit1_o  = rf_we_o && (fwd_raddr1_i == rf_waddr_o) && (fwd_raddr1_i != '0);
    fwd_hit2_o  = rf_we_o && (fwd_raddr2_i == rf_waddr_o) && (fwd_raddr2_i != '0);
    fwd_data1_o = fwd_hit1_o ? rf_wdata_o : '0;
    fwd_data2_o = fwd_hit2_o ? rf_wdata_o : '0;
  end

endmodule
